repl_policy: RTL and testbench

Parametrised bit-PLRU replacement unit for the N-way set-associative cache. It holds one MRU bit per way per set and updates them on hits and fills. On request it returns a registered victim way for a set, preferring invalid ways. It sits beside the tag array in the cache controller and replaces the earlier combinational way picker with sequential state, self-initialisation and a request/response handshake.

---
 rtl/repl_policy.sv | 150 +++++++++++++++
 tb/tb_repl_policy.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/repl_policy.sv
// Bit-PLRU victim selector: one MRU bit per way per set, self-clearing after reset,
// registered victim response. Define REPL_LFSR_EN to rotate the MRU search start with an LFSR.
module repl_policy #(
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int INDEX_BITS = 8,
    parameter int WAY_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [WAYS-1:0]       req_valid_mask,
    input  logic                  req_alloc,
    input  logic                  touch_valid,
    input  logic [INDEX_BITS-1:0] touch_index,
    input  logic [WAY_BITS-1:0]   touch_way,
    output logic                  resp_valid,
    output logic [WAY_BITS-1:0]   resp_way,
    output logic [WAYS-1:0]       resp_onehot,
    output logic                  resp_was_invalid,
    output logic                  init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   init_cnt;
    logic [WAYS-1:0]         mru_mem [SETS];

    logic                    accept_p0;
    logic                    touch_run_p0;
    logic                    same_idx_p0;
    logic [WAYS-1:0]         touch_bits_p0;
    logic [WAYS-1:0]         alloc_bits_p0;
    logic [WAYS-1:0]         fwd_mru_p0;
    logic [WAY_BITS-1:0]     start_way_p0;
    logic [WAY_BITS-1:0]     inv_way_p0;
    logic [WAY_BITS-1:0]     mru_way_p0;
    logic [WAY_BITS-1:0]     victim_p0;
    logic                    any_inv_p0;

`ifdef REPL_LFSR_EN
    logic [7:0]              lfsr;
`endif

    function automatic logic [WAYS-1:0] way_bit(input logic [WAY_BITS-1:0] w);
        logic [WAYS-1:0] b;
        b    = '0;
        b[w] = 1'b1;
        return b;
    endfunction

    // Saturating to all-ones would leave no victim, so that case keeps only the new bits.
    function automatic logic [WAYS-1:0] mru_update(input logic [WAYS-1:0] old_bits,
                                                   input logic [WAYS-1:0] set_bits);
        logic [WAYS-1:0] nv;
        nv = old_bits | set_bits;
        if (&nv)
            nv = set_bits;
        return nv;
    endfunction

    function automatic logic [WAY_BITS-1:0] first_zero(input logic [WAYS-1:0]     bits,
                                                       input logic [WAY_BITS-1:0] start);
        logic [WAY_BITS-1:0] w;
        logic [WAY_BITS-1:0] sel;
        logic                found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            w = start + WAY_BITS'(i);
            if (!found && !bits[w]) begin
                sel   = w;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Stage p0: selection on forwarded MRU bits
    always_comb begin
        accept_p0     = req_valid && (state == S_RUN);
        touch_run_p0  = touch_valid && (state == S_RUN);
        same_idx_p0   = (touch_index == req_index);
        touch_bits_p0 = touch_run_p0 ? way_bit(touch_way) : '0;
        fwd_mru_p0    = (touch_run_p0 && same_idx_p0)
                        ? mru_update(mru_mem[req_index], touch_bits_p0)
                        : mru_mem[req_index];
`ifdef REPL_LFSR_EN
        start_way_p0  = lfsr[WAY_BITS-1:0];
`else
        start_way_p0  = '0;
`endif
        any_inv_p0    = ~&req_valid_mask;
        inv_way_p0    = first_zero(req_valid_mask, '0);
        mru_way_p0    = first_zero(fwd_mru_p0, start_way_p0);
        victim_p0     = any_inv_p0 ? inv_way_p0 : mru_way_p0;
        alloc_bits_p0 = (accept_p0 && req_alloc) ? way_bit(victim_p0) : '0;
    end

    // MRU array: no reset so it can map onto RAM; INIT sweeps it clear instead.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mru_mem[init_cnt] <= '0;
        end else begin
            if (touch_run_p0)
                mru_mem[touch_index] <= mru_update(mru_mem[touch_index],
                                        touch_bits_p0 | (same_idx_p0 ? alloc_bits_p0 : '0));
            if (accept_p0 && req_alloc)
                mru_mem[req_index] <= mru_update(mru_mem[req_index],
                                      alloc_bits_p0 | (same_idx_p0 ? touch_bits_p0 : '0));
        end
    end

    // Stage p1: control state and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_INIT;
            init_cnt         <= '0;
            resp_valid       <= 1'b0;
            resp_way         <= '0;
            resp_onehot      <= '0;
            resp_was_invalid <= 1'b0;
`ifdef REPL_LFSR_EN
            lfsr             <= 8'h01;
`endif
        end else begin
            if (state == S_INIT) begin
                init_cnt <= init_cnt + INDEX_BITS'(1);
                if (init_cnt == INDEX_BITS'(SETS - 1))
                    state <= S_RUN;
            end
            resp_valid <= accept_p0;
            if (accept_p0) begin
                resp_way         <= victim_p0;
                resp_onehot      <= way_bit(victim_p0);
                resp_was_invalid <= any_inv_p0;
`ifdef REPL_LFSR_EN
                lfsr             <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
            end
        end
    end

    assign req_ready = (state == S_RUN);
    assign init_done = (state == S_RUN);

endmodule

// File: tb/tb_repl_policy.sv
// Directed bench for repl_policy (default build): expected victims queued at request time,
// popped and compared one cycle later.
module tb_repl_policy;

    localparam int WAYS       = 4;
    localparam int SETS       = 256;
    localparam int INDEX_BITS = 8;
    localparam int WAY_BITS   = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX_BITS-1:0] req_index;
    logic [WAYS-1:0]       req_valid_mask;
    logic                  req_alloc;
    logic                  touch_valid;
    logic [INDEX_BITS-1:0] touch_index;
    logic [WAY_BITS-1:0]   touch_way;
    logic                  resp_valid;
    logic [WAY_BITS-1:0]   resp_way;
    logic [WAYS-1:0]       resp_onehot;
    logic                  resp_was_invalid;
    logic                  init_done;

    typedef struct {
        string               tag;
        logic [WAY_BITS-1:0] way;
        logic                inv;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    repl_policy #(
        .WAYS(WAYS), .SETS(SETS), .INDEX_BITS(INDEX_BITS), .WAY_BITS(WAY_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_valid_mask(req_valid_mask), .req_alloc(req_alloc),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way),
        .resp_valid(resp_valid), .resp_way(resp_way), .resp_onehot(resp_onehot),
        .resp_was_invalid(resp_was_invalid), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        exp_t            e;
        logic [WAYS-1:0] oh;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_alloc   = 1'b0;
        touch_valid = 1'b0;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.way;
            chk({e.tag, "_vld"}, 32'(resp_valid), 32'd1);
            chk({e.tag, "_way"}, 32'(resp_way), 32'(e.way));
            chk({e.tag, "_oh"},  32'(resp_onehot), 32'(oh));
            chk({e.tag, "_inv"}, 32'(resp_was_invalid), 32'(e.inv));
        end else begin
            chk("idle_vld", 32'(resp_valid), 32'd0);
        end
    endtask

    task automatic req(input logic [INDEX_BITS-1:0] idx, input logic [WAYS-1:0] mask,
                       input logic alloc, input logic [WAY_BITS-1:0] way,
                       input logic inv, input string tag);
        exp_t e;
        req_valid      = 1'b1;
        req_index      = idx;
        req_valid_mask = mask;
        req_alloc      = alloc;
        e.tag = tag;
        e.way = way;
        e.inv = inv;
        exp_q.push_back(e);
    endtask

    task automatic touch(input logic [INDEX_BITS-1:0] idx, input logic [WAY_BITS-1:0] way);
        touch_valid = 1'b1;
        touch_index = idx;
        touch_way   = way;
    endtask

    // Counts edges from reset release until ready; touches set 0 way 0 throughout INIT.
    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < 1000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (req_ready) break;
            touch_valid = (cnt >= 4);
            touch_index = '0;
            touch_way   = '0;
        end
        touch_valid = 1'b0;
        chk({tag, "_len"},  32'(cnt), 32'(SETS));
        chk({tag, "_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"},   32'(resp_valid), 32'd0);
        chk({tag, "_way"},   32'(resp_way), 32'd0);
        chk({tag, "_oh"},    32'(resp_onehot), 32'd0);
        chk({tag, "_inv"},   32'(resp_was_invalid), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_done"},  32'(init_done), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_index      = '0;
        req_valid_mask = '0;
        req_alloc      = 1'b0;
        touch_valid    = 1'b0;
        touch_index    = '0;
        touch_way      = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init");

        // touches during INIT must not have marked set 0
        req(8'd0, 4'hF, 1'b0, 2'd0, 1'b0, "init_touch");
        tick();
        req(8'd5, 4'b1011, 1'b0, 2'd2, 1'b1, "inv_pref");
        tick();

        touch(8'd3, 2'd0); tick();
        touch(8'd3, 2'd1); tick();
        touch(8'd3, 2'd2); tick();
        req(8'd3, 4'hF, 1'b0, 2'd3, 1'b0, "plru_w3");
        tick();
        touch(8'd3, 2'd3); tick();
        req(8'd3, 4'hF, 1'b0, 2'd0, 1'b0, "plru_wrap");
        tick();

        // same-cycle touch and alloc on set 7: MRU must end up 4'b0011
        touch(8'd7, 2'd0);
        req(8'd7, 4'hF, 1'b1, 2'd1, 1'b0, "fwd");
        tick();
        req(8'd7, 4'hF, 1'b0, 2'd2, 1'b0, "fwd_after");
        tick();
        touch(8'd7, 2'd2); tick();
        req(8'd7, 4'hF, 1'b0, 2'd3, 1'b0, "fwd_after2");
        tick();

        // back-to-back allocs on set 9, last one wraps past all-ones
        req(8'd9, 4'hF, 1'b1, 2'd0, 1'b0, "b2b0"); tick();
        req(8'd9, 4'hF, 1'b1, 2'd1, 1'b0, "b2b1"); tick();
        req(8'd9, 4'hF, 1'b1, 2'd2, 1'b0, "b2b2"); tick();
        req(8'd9, 4'hF, 1'b1, 2'd3, 1'b0, "b2b3"); tick();
        req(8'd9, 4'hF, 1'b1, 2'd0, 1'b0, "b2b4"); tick();
        req(8'd9, 4'hF, 1'b0, 2'd1, 1'b0, "b2b5"); tick();

        req(8'd12, 4'b0000, 1'b0, 2'd0, 1'b1, "inv_all"); tick();
        req(8'd12, 4'b0111, 1'b0, 2'd3, 1'b1, "inv_top"); tick();
        tick();
        chk("hold_way", 32'(resp_way), 32'd3);
        chk("hold_inv", 32'(resp_was_invalid), 32'd1);

        // touch and alloc to different sets in one cycle
        touch(8'd10, 2'd1);
        req(8'd11, 4'hF, 1'b1, 2'd0, 1'b0, "split_alloc");
        tick();
        req(8'd10, 4'hF, 1'b0, 2'd0, 1'b0, "split_t"); tick();
        req(8'd11, 4'hF, 1'b0, 2'd1, 1'b0, "split_a"); tick();

        // reset lands in the same cycle as an accepted request
        req_valid      = 1'b1;
        req_index      = 8'd12;
        req_valid_mask = 4'b0111;
        req_alloc      = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_way", 32'(resp_way), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        req(8'd9, 4'hF, 1'b0, 2'd0, 1'b0, "reinit_clr");
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
